// File: rtl/sine_table_loader_if.sv
// Byte stream and table RAM write port of the sine table loader.
// The loader takes the slave view; the host/RAM side takes the master view.
interface sine_table_loader_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 15
);
  logic                     i_ByteValid;
  logic [7:0]               i_Byte;
  logic                     o_ByteReady;
  logic                     o_WriteEnable;
  logic [ADDRESS_WIDTH-1:0] o_WriteAddress;
  logic [DATA_WIDTH-1:0]    o_WriteData;

  modport master (
    output i_ByteValid,
    output i_Byte,
    input  o_ByteReady,
    input  o_WriteEnable,
    input  o_WriteAddress,
    input  o_WriteData
  );

  modport slave (
    input  i_ByteValid,
    input  i_Byte,
    output o_ByteReady,
    output o_WriteEnable,
    output o_WriteAddress,
    output o_WriteData
  );
endinterface

// File: rtl/sine_table_loader.sv
// Boot-time loader for the quarter-wave sine table RAM.
// Optional trailing checksum check: define SINE_LOADER_CHECKSUM_EN.
module sine_table_loader #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 15
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Start,
  sine_table_loader_if.slave bus,
  output logic o_Busy,
  output logic o_Done,
  output logic o_Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_LO,
    S_RECV_HI,
    S_WRITE,
    S_DONE
`ifdef SINE_LOADER_CHECKSUM_EN
    , S_RECV_CK_LO,
    S_RECV_CK_HI
`endif
  } state_e;

  // High-byte bits that do not fit in the sample word.
  localparam logic [7:0] HI_MASK = 8'hFF << (DATA_WIDTH - 8);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               lo_q, lo_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     err_q, err_d;
`ifdef SINE_LOADER_CHECKSUM_EN
  logic [15:0]              sum_q, sum_d;
  logic [7:0]               ck_lo_q, ck_lo_d;
`endif

  logic                  accept;
  logic [DATA_WIDTH-1:0] word;
  logic                  addr_max;

  assign accept   = bus.i_ByteValid && bus.o_ByteReady;
  assign word     = {bus.i_Byte[DATA_WIDTH-9:0], lo_q};
  assign addr_max = (addr_q == {ADDRESS_WIDTH{1'b1}});

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      lo_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
`ifdef SINE_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      ck_lo_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
`ifdef SINE_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      ck_lo_q   <= ck_lo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
`ifdef SINE_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    ck_lo_d   = ck_lo_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_Start) begin
          state_d = S_RECV_LO;
          addr_d  = '0;
          err_d   = 1'b0;
`ifdef SINE_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_RECV_LO: begin
        if (accept) begin
          lo_d    = bus.i_Byte;
          state_d = S_RECV_HI;
        end
      end
      S_RECV_HI: begin
        if (accept) begin
          wr_addr_d = addr_q;
          wr_data_d = word;
          if (|(bus.i_Byte & HI_MASK)) err_d = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // Counter wraps to zero naturally after the last address.
        addr_d = addr_q + 1'b1;
`ifdef SINE_LOADER_CHECKSUM_EN
        sum_d   = sum_q + 16'(wr_data_q);
        state_d = addr_max ? S_RECV_CK_LO : S_RECV_LO;
`else
        state_d = addr_max ? S_DONE : S_RECV_LO;
`endif
      end
`ifdef SINE_LOADER_CHECKSUM_EN
      S_RECV_CK_LO: begin
        if (accept) begin
          ck_lo_d = bus.i_Byte;
          state_d = S_RECV_CK_HI;
        end
      end
      S_RECV_CK_HI: begin
        if (accept) begin
          if ({bus.i_Byte, ck_lo_q} != sum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_ByteReady = 1'b0;
    o_Busy          = 1'b0;
    unique case (state_q)
      S_RECV_LO, S_RECV_HI: begin
        bus.o_ByteReady = 1'b1;
        o_Busy          = 1'b1;
      end
      S_WRITE: o_Busy = 1'b1;
`ifdef SINE_LOADER_CHECKSUM_EN
      S_RECV_CK_LO, S_RECV_CK_HI: begin
        bus.o_ByteReady = 1'b1;
        o_Busy          = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.o_WriteEnable  = (state_q == S_WRITE);
  assign bus.o_WriteAddress = wr_addr_q;
  assign bus.o_WriteData    = wr_data_q;
  assign o_Done             = (state_q == S_DONE);
  assign o_Error            = err_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Randomized bench for sine_table_loader against a write-list model.
// Honours SINE_LOADER_CHECKSUM_EN for the checksum scenario.
module tb_sine_table_loader;
`ifdef SINE_LOADER_CHECKSUM_EN
  localparam int AW = 13;
`else
  localparam int AW = 14;
`endif
  localparam int DW = 15;
  localparam int N  = 1 << AW;
  localparam int HI_LIM = 1 << (DW - 8);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  sine_table_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sine_table_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .i_Start   (start),
    .bus       (bus.slave),
    .o_Busy    (busy),
    .o_Done    (done),
    .o_Error   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  widx = 0;
  int  sum = 0;
  int  last_a = 0;
  int  last_d = 0;
  logic exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_WriteEnable) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(bus.o_WriteAddress), w.a);
        check("wr_data", 32'(bus.o_WriteData), w.d);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.i_ByteValid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.i_ByteValid = 1'b1;
    bus.i_Byte      = b;
    t = 0;
    while (!bus.o_ByteReady && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ByteReady) check("ready_timeout", 32'd0, 32'd1);
    else @(negedge clk);
    bus.i_ByteValid = 1'b0;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
  endfunction

  task automatic model_word(input int lo, input int hi);
    wr_t w;
    w.a = widx % N;
    w.d = (hi % HI_LIM) * 256 + lo;
    if (hi >= HI_LIM) exp_err = 1'b1;
    exp_q.push_back(w);
    sum = (sum + w.d) % 65536;
    last_a = w.a;
    last_d = w.d;
    widx++;
  endtask

  task automatic send_word(input int lo, input int hi, input int gap);
    model_word(lo, hi);
    send_byte(8'(lo), gap);
    send_byte(8'(hi), gap == 0 ? 0 : rgap());
  endtask

  task automatic new_load();
    widx    = 0;
    sum     = 0;
    exp_err = 1'b0;
    pulse_start();
  endtask

  task automatic full_load(input bit gaps, input bit inject);
    for (int i = 0; i < N; i++) begin
      int hi;
      hi = i / 256;
      if (inject && i == 5000) hi = hi + 128;
      send_word(i % 256, hi, gaps ? rgap() : 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ByteReady), 32'd0);
    check({tag, "_we"},    32'(bus.o_WriteEnable), 32'd0);
    check({tag, "_addr"},  32'(bus.o_WriteAddress), 32'd0);
    check({tag, "_data"},  32'(bus.o_WriteData), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    bus.i_ByteValid = 1'b0;
    bus.i_Byte      = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    new_load();
    check("start_busy", 32'(busy), 32'd1);
    model_word(8'h34, 8'h12);
    bus.i_ByteValid = 1'b1;
    bus.i_Byte      = 8'h34;
    check("rdy_lo", 32'(bus.o_ByteReady), 32'd1);
    @(negedge clk);
    bus.i_Byte = 8'h12;
    check("rdy_hi", 32'(bus.o_ByteReady), 32'd1);
    @(negedge clk);
    bus.i_ByteValid = 1'b0;
    check("rdy_bubble", 32'(bus.o_ByteReady), 32'd0);
    check("we_pulse", 32'(bus.o_WriteEnable), 32'd1);
    check("err_clean", 32'(err), 32'd0);
    @(negedge clk);
    check("we_low", 32'(bus.o_WriteEnable), 32'd0);
    check("hold_data", 32'(bus.o_WriteData), 32'h1234);

    send_word(8'h34, 8'h92, 0);
    @(negedge clk);
    check("err_hibit", 32'(err), 32'd1);

    for (int i = 2; i < 100; i++) begin
      if (i == 50) pulse_start();
      send_word($urandom_range(0, 255), $urandom_range(0, HI_LIM - 1),
                rgap());
    end
    check("err_sticky", 32'(err), 32'(exp_err));
    check("busy_mid", 32'(busy), 32'd1);
    send_byte(8'h77, 0);

    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    new_load();
`ifdef SINE_LOADER_CHECKSUM_EN
    full_load(1'b1, 1'b0);
    send_byte(8'(sum % 256), rgap());
    send_byte(8'(sum / 256), rgap());
`else
    full_load(1'b1, 1'b1);
    @(negedge clk);
`endif
    check("end_queue", 32'(exp_q.size()), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_err", 32'(err), 32'(exp_err));
    check("end_addr", 32'(bus.o_WriteAddress), 32'(last_a));
    check("end_data", 32'(bus.o_WriteData), 32'(last_d));

    bus.i_ByteValid = 1'b1;
    bus.i_Byte      = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check("stray_ready", 32'(bus.o_ByteReady), 32'd0);
      check("stray_done", 32'(done), 32'd1);
    end
    bus.i_ByteValid = 1'b0;

    new_load();
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_err", 32'(err), 32'd0);
`ifdef SINE_LOADER_CHECKSUM_EN
    full_load(1'b0, 1'b0);
    send_byte(8'((sum % 256) ^ 1), 0);
    send_byte(8'(sum / 256), 0);
    check("ck_bad_err", 32'(err), 32'd1);
    check("ck_bad_done", 32'(done), 32'd1);
`else
    send_word(8'hAA, 8'h55, 0);
    @(negedge clk);
    check("restart_addr", 32'(bus.o_WriteAddress), 32'd0);
`endif
    repeat (2) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
